// File: rtl/game_engine_2048_if.sv
// Request/response bundle between the button decoder, the 2048 engine and the renderer.
// The master drives move/load requests; the slave (engine) returns board state and status.
interface game_engine_2048_if #(
  parameter int N       = 4,
  parameter int EXP_W   = 4,
  parameter int SCORE_W = 21
);
  logic                   move_valid;
  logic [1:0]             move_dir;
  logic                   load_valid;
  logic [N*N*EXP_W-1:0]   load_board;
  logic                   move_ready;
  logic [N*N*EXP_W-1:0]   board;
  logic [SCORE_W-1:0]     score;
  logic                   move_done;
  logic                   moved;
  logic                   game_over;

  modport master (
    output move_valid, move_dir, load_valid, load_board,
    input  move_ready, board, score, move_done, moved, game_over
  );

  modport slave (
    input  move_valid, move_dir, load_valid, load_board,
    output move_ready, board, score, move_done, moved, game_over
  );
endinterface

// File: rtl/game_engine_2048.sv
// Clocked 2048 engine: one line slid/merged per cycle, LFSR-driven spawn, then a game-over check.
// Cells hold log2 exponents; 0 is an empty cell.
module game_engine_2048 #(
  parameter int          N       = 4,
  parameter int          EXP_W   = 4,
  parameter int          SCORE_W = 21,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic               clk,
  input logic               rst,
  game_engine_2048_if.slave eng
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN);
  localparam int LW = $clog2(N);
  localparam int XW = (SCORE_W > (1 << EXP_W)) ? SCORE_W : (1 << EXP_W);
  localparam int AW = XW + LW + 2;
  localparam logic [EXP_W-1:0] MAXE = '1;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SLIDE = 3'd2;
  localparam logic [2:0] S_SPAWN = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [1:0] DIR_UP   = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;

  logic [2:0]         state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [EXP_W-1:0]   cell_q [NN];
  logic [EXP_W-1:0]   cell_d [NN];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LW-1:0]      line_q, line_d;
  logic [1:0]         dir_q, dir_d;
  logic               changed_q, changed_d;
  logic               spawn_first_q, spawn_first_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      chk_cnt_q, chk_cnt_d;
  logic               init_spawn_q, init_spawn_d;
  logic               init_q, init_d;
  logic               op_move_q, op_move_d;
  logic               move_done_q, move_done_d;
  logic               moved_q, moved_d;
  logic               game_over_q, game_over_d;

  // Slide datapath for the line selected by line_q/dir_q, ordered from the destination edge.
  logic [EXP_W-1:0] ln   [N];
  logic [EXP_W-1:0] comp [N+1];
  logic [EXP_W-1:0] mrg  [N];
  logic [EXP_W-1:0] res  [N];
  logic [AW-1:0]    line_add;
  logic [AW-1:0]    score_sum;
  logic             line_chg;
  logic             skip;

  always_comb begin
    for (int unsigned j = 0; j < N; j++) ln[j] = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (LW'(i) == line_q) begin
        for (int unsigned j = 0; j < N; j++) begin
          case (dir_q)
            DIR_UP:   ln[j] = cell_q[j*N + i];
            DIR_DOWN: ln[j] = cell_q[(N-1-j)*N + i];
            DIR_LEFT: ln[j] = cell_q[i*N + j];
            default:  ln[j] = cell_q[i*N + (N-1-j)];
          endcase
        end
      end
    end

    // Compaction by prepending from the far end keeps order without a data-dependent pointer.
    for (int unsigned j = 0; j <= N; j++) comp[j] = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (ln[N-1-j] != '0) begin
        for (int unsigned m = N - 1; m > 0; m--) comp[m] = comp[m-1];
        comp[0] = ln[N-1-j];
      end
    end

    skip     = 1'b0;
    line_add = '0;
    for (int unsigned k = 0; k < N; k++) mrg[k] = comp[k];
    for (int unsigned k = 0; k < N; k++) begin
      if (skip) begin
        mrg[k] = '0;
        skip   = 1'b0;
      end else if (comp[k] != '0 && comp[k] == comp[k+1] && comp[k] != MAXE) begin
        mrg[k]   = comp[k] + 1'b1;
        line_add = line_add + (AW'(1) << mrg[k]);
        skip     = 1'b1;
      end
    end

    for (int unsigned j = 0; j < N; j++) res[j] = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (mrg[N-1-j] != '0) begin
        for (int unsigned m = N - 1; m > 0; m--) res[m] = res[m-1];
        res[0] = mrg[N-1-j];
      end
    end

    line_chg = 1'b0;
    for (int unsigned j = 0; j < N; j++)
      if (res[j] != ln[j]) line_chg = 1'b1;

    score_sum = AW'(score_q) + line_add;
  end

  // Spawn search and full-board game-over evaluation.
  logic [CW-1:0] start_idx;
  logic [CW-1:0] cur_idx;
  logic          cur_empty;
  logic          any_empty;
  logic          any_merge;

  always_comb begin
    start_idx = CW'(lfsr_q[7:0] % NN);
    cur_idx   = spawn_first_q ? start_idx : idx_q;
    cur_empty = (cell_q[cur_idx] == '0);

    any_empty = 1'b0;
    any_merge = 1'b0;
    for (int unsigned i = 0; i < NN; i++)
      if (cell_q[i] == '0) any_empty = 1'b1;
    for (int unsigned r = 0; r < N; r++)
      for (int unsigned c = 0; c < N - 1; c++)
        if (cell_q[r*N + c] == cell_q[r*N + c + 1] && cell_q[r*N + c] != MAXE)
          any_merge = 1'b1;
    for (int unsigned r = 0; r < N - 1; r++)
      for (int unsigned c = 0; c < N; c++)
        if (cell_q[r*N + c] == cell_q[(r+1)*N + c] && cell_q[r*N + c] != MAXE)
          any_merge = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    for (int unsigned i = 0; i < NN; i++) cell_d[i] = cell_q[i];
    score_d       = score_q;
    line_d        = line_q;
    dir_d         = dir_q;
    changed_d     = changed_q;
    spawn_first_d = spawn_first_q;
    idx_d         = idx_q;
    chk_cnt_d     = chk_cnt_q;
    init_spawn_d  = init_spawn_q;
    init_d        = init_q;
    op_move_d     = op_move_q;
    move_done_d   = 1'b0;
    moved_d       = 1'b0;
    game_over_d   = game_over_q;

    case (state_q)
      S_INIT: begin
        state_d       = S_SPAWN;
        spawn_first_d = 1'b1;
        chk_cnt_d     = '0;
        init_spawn_d  = 1'b1;
        init_d        = 1'b1;
      end

      S_IDLE: begin
        if (eng.load_valid) begin
          for (int unsigned i = 0; i < NN; i++)
            cell_d[i] = eng.load_board[i*EXP_W +: EXP_W];
          op_move_d = 1'b0;
          state_d   = S_CHECK;
        end else if (eng.move_valid) begin
          dir_d     = eng.move_dir;
          changed_d = 1'b0;
          line_d    = '0;
          op_move_d = 1'b1;
          state_d   = S_SLIDE;
        end
      end

      S_SLIDE: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (LW'(i) == line_q) begin
            for (int unsigned j = 0; j < N; j++) begin
              case (dir_q)
                DIR_UP:   cell_d[j*N + i]       = res[j];
                DIR_DOWN: cell_d[(N-1-j)*N + i] = res[j];
                DIR_LEFT: cell_d[i*N + j]       = res[j];
                default:  cell_d[i*N + (N-1-j)] = res[j];
              endcase
            end
          end
        end
        score_d   = ((score_sum >> SCORE_W) != '0) ? '1 : score_sum[SCORE_W-1:0];
        changed_d = changed_q | line_chg;
        line_d    = line_q + 1'b1;
        if (line_q == LW'(N - 1)) begin
          if (changed_q | line_chg) begin
            state_d       = S_SPAWN;
            spawn_first_d = 1'b1;
            chk_cnt_d     = '0;
          end else begin
            state_d     = S_IDLE;
            move_done_d = 1'b1;
          end
        end
      end

      S_SPAWN: begin
        spawn_first_d = 1'b0;
        if (cur_empty || chk_cnt_q == CW'(NN - 1)) begin
          if (cur_empty)
            cell_d[cur_idx] = (lfsr_q[3:0] == 4'd0) ? EXP_W'(2) : EXP_W'(1);
          // The second power-on spawn re-enters SPAWN with a freshly sampled start index.
          if (init_spawn_q) begin
            init_spawn_d  = 1'b0;
            spawn_first_d = 1'b1;
            chk_cnt_d     = '0;
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          idx_d     = (cur_idx == CW'(NN - 1)) ? '0 : cur_idx + 1'b1;
          chk_cnt_d = chk_cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        game_over_d = !any_empty && !any_merge;
        state_d     = (!any_empty && !any_merge) ? S_OVER : S_IDLE;
        move_done_d = !init_q;
        moved_d     = !init_q && op_move_q;
        init_d      = 1'b0;
      end

      S_OVER: ;

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      lfsr_q        <= SEED;
      for (int unsigned i = 0; i < NN; i++) cell_q[i] <= '0;
      score_q       <= '0;
      line_q        <= '0;
      dir_q         <= '0;
      changed_q     <= 1'b0;
      spawn_first_q <= 1'b0;
      idx_q         <= '0;
      chk_cnt_q     <= '0;
      init_spawn_q  <= 1'b0;
      init_q        <= 1'b0;
      op_move_q     <= 1'b0;
      move_done_q   <= 1'b0;
      moved_q       <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      for (int unsigned i = 0; i < NN; i++) cell_q[i] <= cell_d[i];
      score_q       <= score_d;
      line_q        <= line_d;
      dir_q         <= dir_d;
      changed_q     <= changed_d;
      spawn_first_q <= spawn_first_d;
      idx_q         <= idx_d;
      chk_cnt_q     <= chk_cnt_d;
      init_spawn_q  <= init_spawn_d;
      init_q        <= init_d;
      op_move_q     <= op_move_d;
      move_done_q   <= move_done_d;
      moved_q       <= moved_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NN; i++)
      eng.board[i*EXP_W +: EXP_W] = cell_q[i];
  end

  assign eng.move_ready = (state_q == S_IDLE);
  assign eng.score      = score_q;
  assign eng.move_done  = move_done_q;
  assign eng.moved      = moved_q;
  assign eng.game_over  = game_over_q;

endmodule

// File: tb/tb_game_engine_2048.sv
// Directed bench for game_engine_2048 (N=4, EXP_W=4, SEED=16'hACE1) with hand-computed boards.
module tb_game_engine_2048;
  localparam int N       = 4;
  localparam int EXP_W   = 4;
  localparam int SCORE_W = 21;
  localparam int BW      = N * N * EXP_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_engine_2048_if #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W)) bus ();

  game_engine_2048 #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W), .SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .eng (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exactly one cell differs from the expected post-slide board, was empty there, and holds 1 or 2.
  function automatic bit spawn_ok(input logic [BW-1:0] got, input logic [BW-1:0] exp);
    int diffs;
    bit ok;
    diffs = 0;
    ok    = 1'b1;
    for (int i = 0; i < N*N; i++) begin
      logic [3:0] g;
      logic [3:0] e;
      g = got[i*4 +: 4];
      e = exp[i*4 +: 4];
      if (g !== e) begin
        diffs++;
        if (e != 4'd0 || !(g == 4'd1 || g == 4'd2)) ok = 1'b0;
      end
    end
    return ok && (diffs == 1);
  endfunction

  function automatic int small_tiles(input logic [BW-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < N*N; i++)
      if (b[i*4 +: 4] == 4'd1 || b[i*4 +: 4] == 4'd2) n++;
    return n;
  endfunction

  task automatic do_reset();
    int n;
    bus.move_valid = 1'b0;
    bus.load_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (bus.move_ready !== 1'b1 && n < 100) begin tick(); n++; end
  endtask

  // Waits for ready, issues one request, returns cycles to move_done (-1 on timeout).
  task automatic run_op(input logic is_load, input logic [1:0] dir, input logic [BW-1:0] img,
                        output int lat, output logic mv);
    int n;
    n = 0;
    while (bus.move_ready !== 1'b1 && n < 100) begin tick(); n++; end
    bus.load_valid = is_load;
    bus.load_board = img;
    bus.move_valid = !is_load;
    bus.move_dir   = dir;
    tick();
    bus.load_valid = 1'b0;
    bus.move_valid = 1'b0;
    lat = 1;
    while (bus.move_done !== 1'b1 && lat < 100) begin tick(); lat++; end
    mv = bus.moved;
    if (lat >= 100) lat = -1;
  endtask

  localparam logic [BW-1:0] RESET_BOARD = 64'h0000_0001_0000_0002;

  task automatic test_reset();
    int n;
    bus.move_valid = 1'b0;
    bus.load_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.board !== '0) begin errors++; $display("FAIL rst_board: got %h want 0", bus.board); end
    checks++; if (bus.score !== '0) begin errors++; $display("FAIL rst_score: got %0d want 0", bus.score); end
    checks++; if (bus.move_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.move_ready); end
    checks++; if (bus.move_done !== 1'b0 || bus.moved !== 1'b0 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got done=%b moved=%b over=%b want 000", bus.move_done, bus.moved, bus.game_over);
    end
    rst = 1'b0;
    n = 0;
    while (bus.move_ready !== 1'b1 && n < 100) begin
      tick(); n++;
      if (bus.move_done === 1'b1) begin errors++; checks++; $display("FAIL init_done_pulse: got 1 want 0"); end
    end
    checks++; if (n > 36) begin errors++; $display("FAIL init_ready_latency: got %0d want <=36", n); end
    checks++; if (small_tiles(bus.board) !== 2) begin errors++; $display("FAIL init_tile_count: got %0d want 2", small_tiles(bus.board)); end
    checks++; if (bus.board !== RESET_BOARD) begin errors++; $display("FAIL init_board: got %h want %h", bus.board, RESET_BOARD); end
    checks++; if (bus.score !== '0 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL init_status: got score=%0d over=%b want 0 0", bus.score, bus.game_over);
    end
    do_reset();
    checks++; if (bus.board !== RESET_BOARD) begin errors++; $display("FAIL init_repeat: got %h want %h", bus.board, RESET_BOARD); end
  endtask

  task automatic test_merge_pairs();
    int lat;
    logic mv;
    do_reset();
    run_op(1'b1, 2'd0, 64'h2211, lat, mv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d want 2", lat); end
    checks++; if (mv !== 1'b0) begin errors++; $display("FAIL load_moved: got %b want 0", mv); end
    checks++; if (bus.board !== 64'h2211) begin errors++; $display("FAIL load_board: got %h want 2211", bus.board); end
    run_op(1'b0, 2'd2, '0, lat, mv);
    checks++; if (mv !== 1'b1) begin errors++; $display("FAIL pairs_moved: got %b want 1", mv); end
    checks++; if (lat < 7 || lat > 22) begin errors++; $display("FAIL pairs_latency: got %0d want 7..22", lat); end
    checks++; if (bus.move_ready !== 1'b1) begin errors++; $display("FAIL pairs_ready_at_done: got %b want 1", bus.move_ready); end
    checks++; if (bus.score !== 21'd12) begin errors++; $display("FAIL pairs_score: got %0d want 12", bus.score); end
    checks++; if (!spawn_ok(bus.board, 64'h32)) begin errors++; $display("FAIL pairs_board: got %h want 0032 plus one spawn", bus.board); end
  endtask

  task automatic test_no_double_merge();
    int lat;
    logic mv;
    do_reset();
    run_op(1'b1, 2'd0, 64'h1111, lat, mv);
    run_op(1'b0, 2'd2, '0, lat, mv);
    checks++; if (bus.score !== 21'd8) begin errors++; $display("FAIL quad_score: got %0d want 8", bus.score); end
    checks++; if (!spawn_ok(bus.board, 64'h22)) begin errors++; $display("FAIL quad_board: got %h want 0022 plus one spawn", bus.board); end
    run_op(1'b1, 2'd0, 64'h1010, lat, mv);
    run_op(1'b0, 2'd3, '0, lat, mv);
    checks++; if (mv !== 1'b1) begin errors++; $display("FAIL right_moved: got %b want 1", mv); end
    checks++; if (bus.score !== 21'd12) begin errors++; $display("FAIL right_score: got %0d want 12", bus.score); end
    checks++; if (!spawn_ok(bus.board, 64'h2000)) begin errors++; $display("FAIL right_board: got %h want 2000 plus one spawn", bus.board); end
  endtask

  task automatic test_unchanged();
    int lat;
    logic mv;
    do_reset();
    run_op(1'b1, 2'd0, 64'h4321, lat, mv);
    run_op(1'b0, 2'd2, '0, lat, mv);
    checks++; if (lat !== 5) begin errors++; $display("FAIL still_latency: got %0d want 5", lat); end
    checks++; if (mv !== 1'b0) begin errors++; $display("FAIL still_moved: got %b want 0", mv); end
    checks++; if (bus.board !== 64'h4321) begin errors++; $display("FAIL still_board: got %h want 4321", bus.board); end
    checks++; if (bus.score !== '0) begin errors++; $display("FAIL still_score: got %0d want 0", bus.score); end
    run_op(1'b0, 2'd0, '0, lat, mv);
    checks++; if (lat !== 5 || mv !== 1'b0) begin errors++; $display("FAIL still_up: got lat=%0d moved=%b want 5 0", lat, mv); end
  endtask

  task automatic test_max_exp();
    int lat;
    logic mv;
    do_reset();
    run_op(1'b1, 2'd0, 64'hFF, lat, mv);
    run_op(1'b0, 2'd2, '0, lat, mv);
    checks++; if (lat !== 5 || mv !== 1'b0) begin errors++; $display("FAIL max_nomerge: got lat=%0d moved=%b want 5 0", lat, mv); end
    checks++; if (bus.board !== 64'hFF || bus.score !== '0) begin
      errors++; $display("FAIL max_board: got %h score=%0d want 00ff 0", bus.board, bus.score);
    end
  endtask

  task automatic test_game_over();
    int lat;
    int pulses;
    logic mv;
    logic [BW-1:0] cb;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cb[(r*N+c)*4 +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    do_reset();
    run_op(1'b1, 2'd0, cb, lat, mv);
    checks++; if (lat !== 2 || mv !== 1'b0) begin errors++; $display("FAIL over_load: got lat=%0d moved=%b want 2 0", lat, mv); end
    checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got %b want 1", bus.game_over); end
    checks++; if (bus.move_ready !== 1'b0) begin errors++; $display("FAIL over_ready: got %b want 0", bus.move_ready); end
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd2;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.move_done === 1'b1) pulses++;
    end
    bus.move_valid = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL over_ignored: got %0d done pulses want 0", pulses); end
    checks++; if (bus.board !== cb || bus.move_ready !== 1'b0) begin
      errors++; $display("FAIL over_hold: got %h ready=%b want %h 0", bus.board, bus.move_ready, cb);
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL over_rst: got %b want 0", bus.game_over); end
    do_reset();
  endtask

  task automatic test_reset_mid_slide();
    int lat;
    logic mv;
    do_reset();
    run_op(1'b1, 2'd0, 64'h1100, lat, mv);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd2;
    tick();
    bus.move_valid = 1'b0;
    tick();
    checks++; if (bus.score !== 21'd4 || bus.board[15:0] !== 16'h0002) begin
      errors++; $display("FAIL mid_line0: got score=%0d row0=%h want 4 0002", bus.score, bus.board[15:0]);
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.board !== '0 || bus.score !== '0) begin
      errors++; $display("FAIL mid_rst_clear: got %h score=%0d want 0 0", bus.board, bus.score);
    end
    checks++; if (bus.move_done !== 1'b0 || bus.move_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags: got done=%b ready=%b want 0 0", bus.move_done, bus.move_ready);
    end
    do_reset();
    checks++; if (bus.board !== RESET_BOARD) begin errors++; $display("FAIL mid_reinit: got %h want %h", bus.board, RESET_BOARD); end
  endtask

  initial begin
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    bus.load_valid = 1'b0;
    bus.load_board = '0;
    test_reset();
    test_merge_pairs();
    test_no_double_merge();
    test_unchanged();
    test_max_exp();
    test_game_over();
    test_reset_mid_slide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
